ifetch_unit: RTL and testbench

Instruction fetch and sequencing unit for the single-issue MIPS core. It owns the program counter and fetches one 32-bit word per instruction from instruction memory over a request/acknowledge handshake. It holds that word stable and presents its `op`/`func` fields to the control decoder. It then applies the decoder's resolved `brnch`/`jmp` outcome to select the next PC.

---
 rtl/ifetch_unit.sv | 120 ++++++++++++
 tb/tb_ifetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch/sequencing unit: owns the PC, fetches over a req/ack handshake, applies branch/jump.
// Optional IFETCH_PERF_EN adds retired-instruction and fetch-stall counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_vld,
  input  logic        exec_done,
  input  logic        brnch,
  input  logic        jmp,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_instr,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FIELD_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } stateT;

  stateT           state;
  stateT           nextState;
  logic [XLEN-1:0] pcReg;
  logic [XLEN-1:0] pcNext;
  logic [XLEN-1:0] instrReg;
  logic [XLEN-1:0] instrNext;
  logic [XLEN-1:0] pcSeq;
  logic [XLEN-1:0] branchOff;
  logic [XLEN-1:0] jumpTgt;

  // State register; reset discards any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcReg    <= RESET_PC;
      instrReg <= '0;
    end else begin
      state    <= nextState;
      pcReg    <= pcNext;
      instrReg <= instrNext;
    end
  end

  assign pcSeq     = pcReg + XLEN'(4);
  assign branchOff = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
  assign jumpTgt   = {pcSeq[31:28], instrReg[25:0], 2'b00};

  // Next-state and next-PC; jump outranks branch.
  always_comb begin
    nextState = state;
    pcNext    = pcReg;
    instrNext = instrReg;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instrNext = imem_rdata;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          nextState = FETCH;
          if (jmp)        pcNext = jumpTgt;
          else if (brnch) pcNext = pcSeq + branchOff;
          else            pcNext = pcSeq;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign instr_vld = (state == ISSUE);
  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign pc_plus4  = pcSeq;
  assign instr     = instrReg;
  assign op        = instrReg[31:32-FIELD_W];
  assign func      = instrReg[FIELD_W-1:0];

`ifdef IFETCH_PERF_EN
  logic [XLEN-1:0] perfInstr;
  logic [XLEN-1:0] perfStall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perfInstr <= '0;
      perfStall <= '0;
    end else begin
      if (state == ISSUE && exec_done) perfInstr <= perfInstr + XLEN'(1);
      if (state == FETCH && !imem_ack) perfStall <= perfStall + XLEN'(1);
    end
  end

  assign perf_instr = perfInstr;
  assign perf_stall = perfStall;
`endif

  // An unresolved branch/jump at retirement would load X into the PC.
  ctrlKnown: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ISSUE && exec_done) |-> !$isunknown({brnch, jmp}));

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: driver models memory/datapath and predicts fetch addresses,
// a monitor compares every fetch request and issued instruction against the predictions.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        instr_vld;
  logic        exec_done;
  logic        brnch;
  logic        jmp;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;
`endif

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .func       (func),
    .instr_vld  (instr_vld),
    .exec_done  (exec_done),
    .brnch      (brnch),
    .jmp        (jmp),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
`ifdef IFETCH_PERF_EN
    ,
    .perf_instr (perf_instr),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] expAddr[$];
  logic [31:0] expInstr[$];
  logic [31:0] expPc[$];
  logic [31:0] mPc;
  int          mInstr;
  int          mStall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference next-PC from the ISA rules.
  function automatic logic [31:0] modelNext(input logic [31:0] p, input logic [31:0] w,
                                            input logic b, input logic j);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | (32'(w[25:0]) << 2);
    off = int'($signed(w[15:0])) * 4;
    if (b) return seq + 32'(off);
    return seq;
  endfunction

  // Monitor: compare fetch requests and issued instructions against the scoreboard.
  logic        prevReq = 1'b0;
  logic        prevVld = 1'b0;
  logic [31:0] holdAddr, holdInstr, holdPc;
  always @(negedge clk) begin
    if (imem_req && !prevReq) begin
      if (expAddr.size() == 0) chk("fetch_unexpected", imem_addr, 32'hDEAD_DEAD);
      else chk("fetch_addr", imem_addr, expAddr.pop_front());
      holdAddr = imem_addr;
    end else if (imem_req) begin
      chk("addr_stable", imem_addr, holdAddr);
    end
    if (instr_vld && !prevVld) begin
      if (expInstr.size() == 0) chk("issue_unexpected", instr, 32'hDEAD_DEAD);
      else begin
        logic [31:0] ei, ep;
        ei = expInstr.pop_front();
        ep = expPc.pop_front();
        chk("issue_instr", instr, ei);
        chk("issue_op", 32'(op), 32'(ei[31:26]));
        chk("issue_func", 32'(func), 32'(ei[5:0]));
        chk("issue_pc", pc, ep);
        chk("issue_pc4", pc_plus4, ep + 32'd4);
      end
      holdInstr = instr;
      holdPc    = pc;
    end else if (instr_vld) begin
      chk("instr_hold", instr, holdInstr);
      chk("pc_hold", pc, holdPc);
    end
    prevReq = imem_req;
    prevVld = instr_vld;
  end

  int reqCyc;
  logic reqOk;
  task automatic waitReq();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    reqOk  = imem_req;
    reqCyc = cyc;
    if (!reqOk) chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic doInstr(input logic [31:0] w, input int lat, input logic b, input logic j,
                         input int dly);
    waitReq();
    if (!reqOk) return;
    for (int k = 0; k < lat; k++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    expInstr.push_back(w);
    expPc.push_back(mPc);
    mStall += lat;
    @(negedge clk);
    for (int k = 0; k < dly; k++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      brnch      = 1'($urandom);
      jmp        = 1'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b1;
    brnch     = b;
    jmp       = j;
    imem_ack  = 1'($urandom);
    mPc       = modelNext(mPc, w, b, j);
    expAddr.push_back(mPc);
    mInstr++;
    @(negedge clk);
    exec_done = 1'b0;
    brnch     = 1'b0;
    jmp       = 1'b0;
    imem_ack  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int firstCyc;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; brnch = 1'b0; jmp = 1'b0;
    mPc = 32'h0; mInstr = 0; mStall = 0;
    expAddr.push_back(32'h0);
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_vld", 32'(instr_vld), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_func", 32'(func), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc4", pc_plus4, 32'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_release", 32'(imem_req), 32'd1);
    firstCyc = cyc;

    doInstr(32'h0000_0020, 0, 1'b0, 1'b0, 0);
    waitReq();
    chk("seq_gap_cycles", 32'(reqCyc - firstCyc), 32'd2);
    doInstr(32'h0800_0010, 1, 1'b0, 1'b1, 1);   // 0x4 -> 0x40
    doInstr(32'h1000_FFFE, 0, 1'b1, 1'b0, 0);   // backward branch to 0x3C
    doInstr(32'h0BFF_FFFF, 4, 1'b0, 1'b1, 2);   // stalled fetch, jump to 0x0FFFFFFC
    doInstr(32'h0000_0000, 0, 1'b0, 1'b0, 0);   // -> 0x10000000
    doInstr(32'h0800_0010, 0, 1'b1, 1'b1, 0);   // jump beats branch -> 0x10000040
    chk("jmp_prio_pc", mPc, 32'h1000_0040);

    // Reset abort in the ack cycle.
    doInstr(32'h0000_0001, 0, 1'b0, 1'b0, 0);
    waitReq();
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    rst_n      = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("abort_instr", instr, 32'd0);
    chk("abort_pc", pc, 32'd0);
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_vld", 32'(instr_vld), 32'd0);
    expAddr.delete();
    expAddr.push_back(32'h0);
    mPc = 32'h0; mInstr = 0; mStall = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) doInstr(32'($urandom) & 32'h03FF_FFFF, 2, 1'b0, 1'b0, 0);
`ifdef IFETCH_PERF_EN
    chk("perf_instr_3", perf_instr, 32'd3);
    chk("perf_stall_6", perf_stall, 32'd6);
`endif
    doInstr(32'h1000_FFFB, 0, 1'b1, 1'b0, 0);   // 0xC -> 0xFFFFFFFC
    doInstr(32'h0000_0000, 1, 1'b0, 1'b0, 0);   // wraps to 0
    chk("wrap_pc", mPc, 32'h0);

    for (int i = 0; i < 150; i++) begin
      doInstr($urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end
`ifdef IFETCH_PERF_EN
    chk("perf_instr_end", perf_instr, 32'(mInstr));
    chk("perf_stall_end", perf_stall, 32'(mStall));
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
